// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: writeback-select encodings and the memory
// stage FSM state type.
package pipe_pkg;

    localparam logic [1:0] WBSEL_ALU = 2'd0;
    localparam logic [1:0] WBSEL_MEM = 2'd1;
    localparam logic [1:0] WBSEL_PC4 = 2'd2;
    localparam logic [1:0] WBSEL_IMM = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/wb_mux.sv
// Combinational 4:1 writeback value select.
//   sel_i  : writeback select (WBSEL_*)
//   alu_i  : ALU result
//   mem_i  : load data
//   pc4_i  : link value
//   imm_i  : immediate
//   data_o : selected writeback value
module wb_mux
    import pipe_pkg::*;
(
    input  logic [1:0]  sel_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] mem_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] imm_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = alu_i;
        case (sel_i)
            WBSEL_ALU: data_o = alu_i;
            WBSEL_MEM: data_o = mem_i;
            WBSEL_PC4: data_o = pc4_i;
            WBSEL_IMM: data_o = imm_i;
            default:   data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage. Consumes EX_* register outputs, performs word
// loads/stores over a req/ack data-memory handshake, selects the writeback
// value and registers the MEM_* outputs for writeback.
//   clk, rst        : clock, synchronous active-high reset
//   EX_*            : execute-stage pipeline register outputs
//   dmem_rdata/ack  : memory response (ack is a one-cycle pulse)
//   dmem_req/we/addr/wdata : registered memory request, held during WAIT
//   mem_stall       : combinational hold request to upstream stages
//   MEM_*           : registered outputs towards writeback
module mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_Alu_Result,
    input  logic [31:0] EX_Pc4,
    input  logic [4:0]  EX_RegD,
    input  logic [31:0] EX_Wdata,
    input  logic        EX_Wmem,
    input  logic        EX_Rmem,
    input  logic [1:0]  EX_WBsel,
    input  logic        EX_WReg,
    input  logic [31:0] EX_Imm,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        mem_stall,
    output logic [31:0] MEM_Wb_Data,
    output logic [31:0] MEM_Alu_Result,
    output logic [4:0]  MEM_RegD,
    output logic        MEM_WReg,
    output logic        MEM_Fault
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wb_q, wb_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  regd_q, regd_d;
    logic        wreg_q, wreg_d;
    logic        fault_q, fault_d;
    logic        stall;

    logic        memop, is_load, misal, wreg_eff;
    logic [31:0] mem_data, wb_sel;

    assign memop    = EX_Rmem | EX_Wmem;
    // Both flags set counts as a store, so only a pure read returns data.
    assign is_load  = EX_Rmem & ~EX_Wmem;
    assign misal    = |EX_Alu_Result[1:0];
    // Writes to x0 are never committed.
    assign wreg_eff = EX_WReg & (EX_RegD != 5'd0);
    // Load data reaches the mux only on the ack cycle; otherwise WBsel=1 gives 0.
    assign mem_data = (state_q == WAIT && dmem_ack && is_load) ? dmem_rdata : 32'd0;

    wb_mux u_wb_mux (
        .sel_i  (EX_WBsel),
        .alu_i  (EX_Alu_Result),
        .mem_i  (mem_data),
        .pc4_i  (EX_Pc4),
        .imm_i  (EX_Imm),
        .data_o (wb_sel)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wb_d    = wb_q;
        alu_d   = alu_q;
        regd_d  = regd_q;
        wreg_d  = wreg_q;
        fault_d = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                // Every IDLE cycle captures the instruction; memops capture a bubble.
                wb_d   = wb_sel;
                alu_d  = EX_Alu_Result;
                regd_d = EX_RegD;
                if (!memop) begin
                    wreg_d = wreg_eff;
                end else if (misal) begin
                    wreg_d  = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    stall   = 1'b1;
                    state_d = WAIT;
                    req_d   = 1'b1;
                    we_d    = EX_Wmem;
                    addr_d  = {EX_Alu_Result[31:2], 2'b00};
                    wdata_d = EX_Wdata;
                    cnt_d   = 8'd0;
                    wreg_d  = 1'b0;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wb_d    = wb_sel;
                    alu_d   = EX_Alu_Result;
                    regd_d  = EX_RegD;
                    wreg_d  = wreg_eff;
                end else if (cnt_q == TMO_LAST) begin
                    // Abandon the access; upstream is released this cycle.
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wreg_d  = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wb_q    <= 32'd0;
            alu_q   <= 32'd0;
            regd_q  <= 5'd0;
            wreg_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wb_q    <= wb_d;
            alu_q   <= alu_d;
            regd_q  <= regd_d;
            wreg_q  <= wreg_d;
            fault_q <= fault_d;
        end
    end

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign mem_stall      = stall & ~rst;
    assign MEM_Wb_Data    = wb_q;
    assign MEM_Alu_Result = alu_q;
    assign MEM_RegD       = regd_q;
    assign MEM_WReg       = wreg_q;
    assign MEM_Fault      = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short timeout (4 WAIT cycles).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] EX_Alu_Result, EX_Pc4, EX_Wdata, EX_Imm;
    logic [4:0]  EX_RegD;
    logic        EX_Wmem, EX_Rmem, EX_WReg;
    logic [1:0]  EX_WBsel;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, mem_stall, MEM_WReg, MEM_Fault;
    logic [31:0] dmem_addr, dmem_wdata, MEM_Wb_Data, MEM_Alu_Result;
    logic [4:0]  MEM_RegD;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .EX_Alu_Result(EX_Alu_Result), .EX_Pc4(EX_Pc4), .EX_RegD(EX_RegD),
        .EX_Wdata(EX_Wdata), .EX_Wmem(EX_Wmem), .EX_Rmem(EX_Rmem),
        .EX_WBsel(EX_WBsel), .EX_WReg(EX_WReg), .EX_Imm(EX_Imm),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .mem_stall(mem_stall),
        .MEM_Wb_Data(MEM_Wb_Data), .MEM_Alu_Result(MEM_Alu_Result),
        .MEM_RegD(MEM_RegD), .MEM_WReg(MEM_WReg), .MEM_Fault(MEM_Fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic [31:0] alu, input logic [31:0] pc4,
                          input logic [4:0] regd, input logic [31:0] wdata,
                          input logic wmem, input logic rmem, input logic [1:0] wbsel,
                          input logic wreg, input logic [31:0] imm);
        EX_Alu_Result = alu;  EX_Pc4 = pc4;    EX_RegD = regd;
        EX_Wdata      = wdata; EX_Wmem = wmem; EX_Rmem = rmem;
        EX_WBsel      = wbsel; EX_WReg = wreg; EX_Imm  = imm;
    endtask

    task automatic nop();
        set_ex(32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        set_ex(32'h0000_0100, 32'h44, 5'd7, 32'hAA, 1'b0, 1'b1, 2'd1, 1'b1, 32'h55);
        tick(); tick();
        #1;
        chk("rst_req",   32'(dmem_req),  32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_wb",    MEM_Wb_Data,    32'd0);
        chk("rst_wreg",  32'(MEM_WReg),  32'd0);
        chk("rst_fault", 32'(MEM_Fault), 32'd0);
        nop();
        rst = 1'b0;
        tick();

        // ALU op pass-through
        set_ex(32'h10, 32'h1004, 5'd5, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h7000);
        #1 chk("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("alu_wb",   MEM_Wb_Data,     32'h10);
        chk("alu_regd", 32'(MEM_RegD),   32'd5);
        chk("alu_wreg", 32'(MEM_WReg),   32'd1);
        chk("alu_res",  MEM_Alu_Result, 32'h10);
        chk("alu_req",  32'(dmem_req),   32'd0);
        // PC4, IMM, WBsel=1 without load, and x0 destination
        set_ex(32'h10, 32'h1004, 5'd6, 32'd0, 1'b0, 1'b0, 2'd2, 1'b1, 32'h7000);
        tick();
        chk("pc4_wb", MEM_Wb_Data, 32'h1004);
        set_ex(32'h10, 32'h1004, 5'd6, 32'd0, 1'b0, 1'b0, 2'd3, 1'b1, 32'h7000);
        tick();
        chk("imm_wb", MEM_Wb_Data, 32'h7000);
        set_ex(32'h10, 32'h1004, 5'd6, 32'd0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h7000);
        tick();
        chk("wbmem_noload", MEM_Wb_Data, 32'd0);
        set_ex(32'h10, 32'h1004, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h7000);
        tick();
        chk("x0_wreg", 32'(MEM_WReg), 32'd0);

        // Load at 0x100, ack during the third request cycle
        set_ex(32'h100, 32'h2004, 5'd7, 32'd0, 1'b0, 1'b1, 2'd1, 1'b1, 32'd0);
        #1 chk("ld_stall0", 32'(mem_stall), 32'd1);
        chk("ld_noreq0", 32'(dmem_req), 32'd0);
        tick();
        chk("ld_req1",   32'(dmem_req),  32'd1);
        chk("ld_addr",   dmem_addr,      32'h100);
        chk("ld_we",     32'(dmem_we),   32'd0);
        chk("ld_bubble", 32'(MEM_WReg),  32'd0);
        chk("ld_stall1", 32'(mem_stall), 32'd1);
        tick();
        chk("ld_req2",   32'(dmem_req),  32'd1);
        chk("ld_stall2", 32'(mem_stall), 32'd1);
        tick();
        chk("ld_req3",   32'(dmem_req),  32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1 chk("ld_stall_ack", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        chk("ld_req_off", 32'(dmem_req), 32'd0);
        chk("ld_wb",      MEM_Wb_Data,   32'hDEAD_BEEF);
        chk("ld_wreg",    32'(MEM_WReg), 32'd1);
        chk("ld_regd",    32'(MEM_RegD), 32'd7);
        nop();

        // Store to 0x204, immediate ack
        set_ex(32'h204, 32'h3004, 5'd0, 32'h1234_5678, 1'b1, 1'b0, 2'd0, 1'b0, 32'd0);
        #1 chk("st_stall0", 32'(mem_stall), 32'd1);
        tick();
        chk("st_req",   32'(dmem_req), 32'd1);
        chk("st_we",    32'(dmem_we),  32'd1);
        chk("st_addr",  dmem_addr,     32'h204);
        chk("st_wdata", dmem_wdata,    32'h1234_5678);
        dmem_ack = 1'b1;
        #1 chk("st_stall_ack", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("st_req_off", 32'(dmem_req), 32'd0);
        chk("st_wreg",    32'(MEM_WReg), 32'd0);
        nop();

        // Misaligned load
        set_ex(32'h102, 32'h4004, 5'd8, 32'd0, 1'b0, 1'b1, 2'd1, 1'b1, 32'd0);
        #1 chk("mis_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("mis_req",   32'(dmem_req),  32'd0);
        chk("mis_fault", 32'(MEM_Fault), 32'd1);
        chk("mis_wreg",  32'(MEM_WReg),  32'd0);
        nop();
        tick();
        chk("mis_fault_off", 32'(MEM_Fault), 32'd0);

        // Timeout: 4 WAIT cycles without ack
        set_ex(32'h300, 32'h5004, 5'd3, 32'd0, 1'b0, 1'b1, 2'd1, 1'b1, 32'd0);
        tick();
        chk("to_req1", 32'(dmem_req), 32'd1);
        tick();
        chk("to_req2", 32'(dmem_req), 32'd1);
        tick();
        chk("to_req3", 32'(dmem_req), 32'd1);
        chk("to_stall3", 32'(mem_stall), 32'd1);
        tick();
        chk("to_req4", 32'(dmem_req), 32'd1);
        #1 chk("to_stall4", 32'(mem_stall), 32'd0);
        tick();
        chk("to_req_off", 32'(dmem_req),  32'd0);
        chk("to_fault",   32'(MEM_Fault), 32'd1);
        chk("to_wreg",    32'(MEM_WReg),  32'd0);
        nop();
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        tick();
        dmem_ack = 1'b0;
        chk("to_stray_req",   32'(dmem_req),  32'd0);
        chk("to_stray_fault", 32'(MEM_Fault), 32'd0);
        chk("to_stray_wb",    MEM_Wb_Data,    32'd0);

        // Reset while in WAIT, then a late ack
        set_ex(32'h400, 32'h6004, 5'd9, 32'd0, 1'b0, 1'b1, 2'd1, 1'b1, 32'd0);
        tick();
        chk("rw_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        nop();
        tick();
        rst = 1'b0;
        chk("rw_req_off", 32'(dmem_req), 32'd0);
        chk("rw_addr",    dmem_addr,     32'd0);
        chk("rw_regd",    32'(MEM_RegD), 32'd0);
        chk("rw_alu",     MEM_Alu_Result, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hFACE_CAFE;
        #1 chk("rw_stall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("rw_late_req",  32'(dmem_req), 32'd0);
        chk("rw_late_wreg", 32'(MEM_WReg), 32'd0);
        chk("rw_late_wb",   MEM_Wb_Data,   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the EX_* pipeline register outputs and performs word loads/stores over a req/ack data-memory handshake.
- Selects the writeback value and registers MEM_* outputs for the writeback stage.
- Drives mem_stall so upstream stages hold while a memory access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without dmem_ack before the access is abandoned (range 1..255).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
EX_Alu_Result  input  32  ALU result; memory byte address for loads/stores
EX_Pc4  input  32  PC+4 (link value)
EX_RegD  input  5  destination register
EX_Wdata  input  32  store data
EX_Wmem  input  1  store
EX_Rmem  input  1  load
EX_WBsel  input  2  writeback select: 0 ALU, 1 load data, 2 Pc4, 3 Imm
EX_WReg  input  1  register write enable
EX_Imm  input  32  immediate (LUI path)
dmem_rdata  input  32  load data, valid with dmem_ack
dmem_ack  input  1  access complete, single-cycle pulse
dmem_req  output  1  request, registered
dmem_we  output  1  1 = store, registered
dmem_addr  output  32  word-aligned address, registered
dmem_wdata  output  32  store data, registered
mem_stall  output  1  combinational; upstream holds EX_* stable while high
MEM_Wb_Data  output  32  writeback value
MEM_Alu_Result  output  32  ALU result, used for forwarding
MEM_RegD  output  5  destination register
MEM_WReg  output  1  register write enable
MEM_Fault  output  1  one-cycle pulse on misaligned access or timeout

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. The reset is synchronous and active-high on clk; it takes priority over every other event.
- Memory op: memop = EX_Rmem | EX_Wmem. If both are set, treat the op as a store.
- Misaligned: EX_Alu_Result[1:0] != 0.
- FSM states: IDLE and WAIT. The wait counter is 8 bits wide.
- IDLE, no memop:
  - One-cycle pass-through; mem_stall = 0.
  - MEM_Wb_Data is muxed by EX_WBsel. WBsel = 1 without a load yields 0.
- IDLE, memop, misaligned:
  - No request is issued and mem_stall = 0.
  - Next edge: MEM_WReg = 0 (bubble) and MEM_Fault = 1 for one cycle.
- IDLE, memop, aligned:
  - mem_stall = 1.
  - Next edge: go to WAIT, dmem_req = 1, dmem_we = EX_Wmem, dmem_addr = EX_Alu_Result, dmem_wdata = EX_Wdata, counter = 0.
  - MEM outputs load a bubble (MEM_WReg = 0).
- WAIT:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until ack or timeout.
  - mem_stall = !dmem_ack.
  - On dmem_ack:
    - Next state is IDLE and dmem_req is cleared.
    - The MEM register captures the instruction; for a load with WBsel = 1, MEM_Wb_Data = dmem_rdata.
    - Stores write MEM_WReg = EX_WReg (normally 0).
  - No ack and counter == TIMEOUT_CYCLES-1:
    - Next state is IDLE, dmem_req is cleared and mem_stall = 0 in that cycle.
    - Bubble is written and MEM_Fault = 1.
  - Otherwise the counter increments.
- Latency: non-memory op 1 cycle. Load/store is 2 + k cycles, where k is the number of WAIT cycles before ack (minimum 2).
- dmem_ack while in IDLE is ignored.
- rst while in WAIT: the access is abandoned, dmem_req falls on that edge, and a late ack is ignored.
- MEM_WReg is forced to 0 when EX_RegD == 0.
- MEM_Alu_Result and MEM_RegD always track the captured instruction. A bubble keeps MEM_RegD but clears MEM_WReg.

Decomposition:
- Package pipe_pkg holds:
  - WBSEL_ALU = 0, WBSEL_MEM = 1, WBSEL_PC4 = 2, WBSEL_IMM = 3
  - mem_state_t enum {IDLE, WAIT}
- Single sub-module wb_mux: combinational 4:1 writeback select, reused later by the writeback stage.

Test Plan:
- ALU op, EX_Alu_Result = 0x0000_0010, WBsel = 0, RegD = 5, WReg = 1 -> next cycle MEM_Wb_Data = 0x10, MEM_RegD = 5, MEM_WReg = 1; mem_stall never asserted.
- Load from addr 0x100, ack with rdata = 0xDEAD_BEEF 3 cycles after req -> dmem_req held 3 cycles with addr = 0x100, we = 0; mem_stall high 3 cycles; MEM_Wb_Data = 0xDEAD_BEEF on the following edge.
- Store to 0x204 with data 0x1234_5678 and immediate ack -> dmem_we = 1, dmem_wdata = 0x1234_5678 for 1 cycle; MEM_WReg = 0; stall released on the ack cycle.
- Load at 0x102 -> no dmem_req; MEM_Fault pulses 1 cycle; MEM_WReg = 0; no stall.
- TIMEOUT_CYCLES = 4, load with no ack -> dmem_req high 4 cycles then low; MEM_Fault = 1; later stray ack ignored.
- rst asserted in WAIT, then ack 1 cycle later -> all outputs 0; FSM stays IDLE; MEM_WReg remains 0.
